// File: rtl/imu_moving_average.sv
// imu_moving_average: multi-channel signed boxcar moving-average filter.
// Each channel keeps a ring buffer of the last WIN = 2**LOG2_WIN samples and a
// running sum. After WIN beats have been accepted, every further beat emits a
// registered average one cycle later.
// Optional feature macro: MAVG_ROUND_EN rounds half-up. Without it the
// average is floored (arithmetic shift).
module imu_moving_average #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOG2_WIN   = 3
) (
    input  logic                           clk,
    input  logic                           i_rstn,
    input  logic                           i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   i_data,
    input  logic                           i_clear,
    output logic                           o_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_data,
    output logic                           o_primed
);

    localparam int unsigned WIN    = 1 << LOG2_WIN;
    localparam int unsigned ACC_W  = DATA_WIDTH + LOG2_WIN;
    localparam int unsigned PTR_W  = (LOG2_WIN > 0) ? LOG2_WIN : 1;
    localparam int unsigned FILL_W = LOG2_WIN + 1;
`ifdef MAVG_ROUND_EN
    // One guard bit so the rounding bias can never overflow the sum.
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned RND    = WIN >> 1;
`else
    localparam int unsigned SUM_W  = ACC_W;
`endif

    logic        [DATA_WIDTH-1:0]         ring_mem [NUM_CH][WIN];
    logic signed [ACC_W-1:0]              acc      [NUM_CH];
    logic signed [ACC_W-1:0]              acc_next [NUM_CH];
    logic        [PTR_W-1:0]              wr_ptr;
    logic        [PTR_W-1:0]              ptr_next;
    logic        [FILL_W-1:0]             fill_cnt;
    logic        [FILL_W-1:0]             fill_next;
    logic                                 accept;
    logic                                 full;
    logic        [NUM_CH*DATA_WIDTH-1:0]  avg;

    // Shared pointer / fill bookkeeping and beat acceptance.
    always_comb begin
        accept    = i_valid & ~i_clear;
        full      = (fill_cnt == FILL_W'(WIN));
        fill_next = full ? fill_cnt : fill_cnt + FILL_W'(1);
        ptr_next  = (wr_ptr == PTR_W'(WIN - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end

    // Per-channel running sum update and scaled average; the oldest sample is
    // only subtracted once the window is full, so stale buffer contents never matter.
    always_comb begin
        logic signed [DATA_WIDTH-1:0] new_s;
        logic signed [DATA_WIDTH-1:0] old_s;
        logic signed [SUM_W-1:0]      sum;
        new_s = '0;
        old_s = '0;
        sum   = '0;
        avg   = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            new_s       = signed'(i_data[k*DATA_WIDTH +: DATA_WIDTH]);
            old_s       = full ? signed'(ring_mem[k][wr_ptr]) : '0;
            acc_next[k] = acc[k] + ACC_W'(new_s) - ACC_W'(old_s);
`ifdef MAVG_ROUND_EN
            sum = SUM_W'(acc_next[k]) + signed'(SUM_W'(RND));
`else
            sum = SUM_W'(acc_next[k]);
`endif
            avg[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sum >>> LOG2_WIN);
        end
    end

    // Sample history; contents are don't-care until the window has filled.
    always_ff @(posedge clk) begin
        if (i_rstn && accept) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                ring_mem[k][wr_ptr] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Filter state and registered outputs; clear beats a simultaneous sample.
    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            for (int k = 0; k < int'(NUM_CH); k++) acc[k] <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_primed <= 1'b0;
        end else if (i_clear) begin
            for (int k = 0; k < int'(NUM_CH); k++) acc[k] <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            o_valid  <= 1'b0;
            o_primed <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (accept) begin
                for (int k = 0; k < int'(NUM_CH); k++) acc[k] <= acc_next[k];
                wr_ptr   <= ptr_next;
                fill_cnt <= fill_next;
                if (fill_next == FILL_W'(WIN)) begin
                    o_valid  <= 1'b1;
                    o_data   <= avg;
                    o_primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/imu_moving_average.md
# imu_moving_average

Multi-channel, signed, boxcar moving-average filter for the ADXL345 acquisition path. It sits between the SPI sample unpacker and downstream consumers such as the UART formatter and threshold logic. It filters all axes of each sample beat in parallel with a valid-qualified streaming handshake. It uses a true per-channel ring buffer, a power-of-two window, a flush input, and a "primed" indication.

## Interface
- NUM_CH, 3, number of channels (axes) per sample beat; 1..8
- DATA_WIDTH, 16, width of each two's-complement sample
- LOG2_WIN, 3, window length WIN = 2**LOG2_WIN samples; 0..8
- clk  input  1  clock; all logic on rising edge
- i_rstn  input  1  synchronous, active-low reset
- i_valid  input  1  sample beat present on i_data this cycle
- i_data  input  NUM_CH*DATA_WIDTH  packed signed samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_clear  input  1  synchronous flush of filter history
- o_valid  output  1  one-cycle pulse; o_data holds a new average
- o_data  output  NUM_CH*DATA_WIDTH  packed signed averages, same channel order
- o_primed  output  1  high once WIN beats have been accepted since the last reset or clear

## Operation
- Per channel: a ring buffer of WIN x DATA_WIDTH entries and a signed accumulator of DATA_WIDTH+LOG2_WIN bits. The accumulator never overflows by construction.
- One shared write pointer wr_ptr (LOG2_WIN bits, wraps WIN-1 -> 0) and a fill counter fill_cnt (0..WIN, saturating).
- On an accepted beat (i_valid=1, i_clear=0), for each channel:
  - old = (fill_cnt==WIN) ? buf[wr_ptr] : 0
  - acc_next = acc + sext(new) - sext(old)
  - buf[wr_ptr] <= new
  - acc <= acc_next
- Then wr_ptr increments with wrap, and fill_cnt increments unless it is already WIN.
- Average = acc_next >>> LOG2_WIN (arithmetic shift), truncated to DATA_WIDTH. The result always fits.
- Because old is forced to 0 while filling, buffer contents are don't-care after reset or clear. No memory-initialisation pass is needed.
- o_valid and o_data are emitted only when fill_cnt after the update equals WIN. Beats during the fill phase update state silently.
- i_clear=1: acc, wr_ptr, fill_cnt, o_primed and o_valid go to 0. o_data holds its value. i_clear takes priority over a simultaneous i_valid, and that beat is discarded.
- i_valid=0: no state change; o_valid=0 next cycle.
- LOG2_WIN=0: the block degenerates to a one-cycle registered pass-through with o_valid from the first beat.

## Timing
- Reset (i_rstn=0 at a clock edge): o_valid=0, o_data=0, o_primed=0, acc=0, wr_ptr=0, fill_cnt=0. Reset asserted mid-stream discards all history, including an in-flight beat.
- Latency: beat accepted at edge n produces o_valid=1 with its average during cycle n+1 (registered output, one cycle).
- Throughput: one beat per clock. Back-to-back i_valid is sustained indefinitely. Gaps of any length are allowed.
- First output: the WIN-th accepted beat after reset or clear. o_primed rises in the same cycle as that first o_valid and stays high until the next reset or clear.
- There is no backpressure; the consumer must accept every o_valid pulse.
- All channels update in the same cycle. No channel skew.

## Configuration
- MAVG_ROUND_EN defined: average = (acc_next + 2**(LOG2_WIN-1)) >>> LOG2_WIN, which is round-half-up (toward +inf). The add uses one extra guard bit so it cannot overflow. When LOG2_WIN=0 nothing is added.
- MAVG_ROUND_EN undefined: average = acc_next >>> LOG2_WIN, which is floor (toward -inf). There is no rounding adder.

## Test plan
- Constant fill: LOG2_WIN=3, 8 beats of ch0=100, ch1=-100, ch2=0 -> no o_valid for beats 1-7; beat 8 gives o_valid next cycle with o_data={0,-100,100} and o_primed=1.
- Sliding window: after priming with zeros, feed ch0=8,16,24,... one per clock -> successive ch0 outputs 1,3,6,10,15,21,28,36, then +8 per beat; o_valid is asserted every cycle.
- Rounding: 7 zeros then 4 (sum 4) -> 0 without the macro, 1 with it. 7 zeros then -4 -> -1 without the macro, 0 with it.
- Extremes: DATA_WIDTH=16, 8 beats of -32768 -> -32768. 8 beats of 32767 -> 32767. No wrap in either case.
- Clear and reset mid-stream: prime with 80, assert i_clear together with i_valid (ch0=800) -> o_primed=0, the beat is dropped, o_data holds its prior value (80). The next 8 beats of 40 yield 40 only on the 8th. Repeat the sequence with i_rstn low instead of i_clear -> o_data=0.
- Gaps: prime, then present beats with random 0-5 idle cycles between them -> outputs match the gap-free reference sequence, with o_valid exactly one cycle after each beat.
